// File: rtl/reset_sequencer.sv
// Board reset sequencer: releases NUM_STAGES ordered resets once the PLLs are stably locked,
// the debounced button is up and no software request is pending. RESET_SEQUENCER_WDT_EN adds a RUN watchdog.
module reset_sequencer #(
  parameter int NUM_LOCKS          = 2,
  parameter int NUM_STAGES         = 3,
  parameter int MIN_HOLD           = 4,
  parameter int LOCK_STABLE_CYCLES = 64,
  parameter int STAGE_DELAY        = 16,
  parameter int DEBOUNCE_CYCLES    = 1000
`ifdef RESET_SEQUENCER_WDT_EN
  , parameter int WDT_CYCLES       = 1_000_000
`endif
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [NUM_LOCKS-1:0]  pll_locked_i,
  input  logic                  btn_n_i,
  input  logic                  sw_reset_i,
  input  logic                  lost_lock_clr_i,
`ifdef RESET_SEQUENCER_WDT_EN
  input  logic                  wdt_kick_i,
  output logic                  wdt_fired_o,
`endif
  output logic [NUM_STAGES-1:0] reset_o,
  output logic                  ready_o,
  output logic                  lost_lock_o
);

  localparam int REL_MAX  = STAGE_DELAY * (NUM_STAGES - 1);
  localparam int HOLD_W   = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
  localparam int STABLE_W = (LOCK_STABLE_CYCLES > 0) ? $clog2(LOCK_STABLE_CYCLES + 1) : 1;
  localparam int REL_W    = (REL_MAX > 0) ? $clog2(REL_MAX + 1) : 1;
  localparam int DEB_W    = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_HOLD, S_WAIT_LOCK, S_RELEASE, S_RUN} state_t;

  logic [NUM_LOCKS-1:0]  r_lock_s1, r_lock_s2;
  logic                  r_btn_s1, r_btn_s2;
  logic                  r_btn_pressed;
  logic [DEB_W-1:0]      r_deb_cnt;
  state_t                r_state;
  logic [HOLD_W-1:0]     r_hold_cnt;
  logic [STABLE_W-1:0]   r_stable_cnt;
  logic [REL_W-1:0]      r_rel_cnt;
  logic [NUM_STAGES-1:0] r_reset;
  logic                  r_ready;
  logic                  r_lost_lock;

  logic                  w_btn_sample;
  logic                  w_all_locked;
  logic                  w_user_cause;
  logic                  w_wdt_fire;
  logic                  w_run_abort;
  logic                  w_to_hold;
  logic                  w_lost_set;
  logic [REL_W-1:0]      w_rel_next;

  // Asynchronous inputs are only used after two flops in the board clock domain.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_lock_s1 <= '0;
      r_lock_s2 <= '0;
      r_btn_s1  <= 1'b1;
      r_btn_s2  <= 1'b1;
    end else begin
      r_lock_s1 <= pll_locked_i;
      r_lock_s2 <= r_lock_s1;
      r_btn_s1  <= btn_n_i;
      r_btn_s2  <= r_btn_s1;
    end
  end

  assign w_btn_sample = ~r_btn_s2;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_btn_pressed <= 1'b0;
      r_deb_cnt     <= '0;
    end else if (w_btn_sample != r_btn_pressed) begin
      if (r_deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
        r_btn_pressed <= w_btn_sample;
        r_deb_cnt     <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DEB_W'(1);
      end
    end else begin
      r_deb_cnt <= '0;
    end
  end

  assign w_all_locked = &r_lock_s2;
  assign w_user_cause = r_btn_pressed | sw_reset_i;
  assign w_run_abort  = w_user_cause | ~w_all_locked | w_wdt_fire;
  assign w_to_hold    = ((r_state == S_WAIT_LOCK) && w_user_cause) ||
                        (((r_state == S_RELEASE) || (r_state == S_RUN)) && w_run_abort);
  assign w_lost_set   = ((r_state == S_RELEASE) || (r_state == S_RUN)) && !w_all_locked;
  assign w_rel_next   = r_rel_cnt + REL_W'(1);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state      <= S_HOLD;
      r_hold_cnt   <= '0;
      r_stable_cnt <= '0;
      r_rel_cnt    <= '0;
      r_reset      <= '1;
      r_ready      <= 1'b0;
    end else if (w_to_hold) begin
      r_state      <= S_HOLD;
      r_hold_cnt   <= '0;
      r_stable_cnt <= '0;
      r_rel_cnt    <= '0;
      r_reset      <= '1;
      r_ready      <= 1'b0;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (w_user_cause) begin
            r_hold_cnt <= '0;
          end else if (r_hold_cnt == HOLD_W'(MIN_HOLD)) begin
            r_state      <= S_WAIT_LOCK;
            r_hold_cnt   <= '0;
            r_stable_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (!w_all_locked) begin
            r_stable_cnt <= '0;
          end else if (r_stable_cnt == STABLE_W'(LOCK_STABLE_CYCLES - 1)) begin
            r_stable_cnt <= '0;
            r_rel_cnt    <= '0;
            r_reset[0]   <= 1'b0;
            if (NUM_STAGES == 1) begin
              r_state <= S_RUN;
              r_ready <= 1'b1;
            end else begin
              r_state <= S_RELEASE;
            end
          end else begin
            r_stable_cnt <= r_stable_cnt + STABLE_W'(1);
          end
        end
        S_RELEASE: begin
          r_rel_cnt <= w_rel_next;
          // Stages only ever clear here, so the release order stays monotonic.
          for (int k = 1; k < NUM_STAGES; k++) begin
            if (w_rel_next == REL_W'(STAGE_DELAY * k)) r_reset[k] <= 1'b0;
          end
          if (w_rel_next == REL_W'(REL_MAX)) begin
            r_state <= S_RUN;
            r_ready <= 1'b1;
          end
        end
        S_RUN: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_HOLD;
          r_reset <= '1;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i)           r_lost_lock <= 1'b0;
    else if (w_lost_set)      r_lost_lock <= 1'b1;
    else if (lost_lock_clr_i) r_lost_lock <= 1'b0;
  end

`ifdef RESET_SEQUENCER_WDT_EN
  localparam int WDT_W = (WDT_CYCLES > 0) ? $clog2(WDT_CYCLES + 1) : 1;

  logic [WDT_W-1:0] r_wdt_cnt;
  logic             r_wdt_fired;

  assign w_wdt_fire = (r_state == S_RUN) && !wdt_kick_i && (r_wdt_cnt == WDT_W'(WDT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_wdt_cnt   <= '0;
      r_wdt_fired <= 1'b0;
    end else begin
      if ((r_state != S_RUN) || w_to_hold || wdt_kick_i) r_wdt_cnt <= '0;
      else                                                  r_wdt_cnt <= r_wdt_cnt + WDT_W'(1);
      if (w_wdt_fire)           r_wdt_fired <= 1'b1;
      else if (lost_lock_clr_i) r_wdt_fired <= 1'b0;
    end
  end

  assign wdt_fired_o = r_wdt_fired;
`else
  assign w_wdt_fire = 1'b0;
`endif

  assign reset_o     = r_reset;
  assign ready_o     = r_ready;
  assign lost_lock_o = r_lost_lock;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: release-latency table, multi-cycle corner sequences and random stimulus
// compared every cycle against a timing model (watchdog part only when RESET_SEQUENCER_WDT_EN is defined).
module tb_reset_sequencer;
  localparam int NL = 2;
  localparam int NS = 3;
  localparam int MH = 4;
  localparam int LS = 64;
  localparam int SD = 16;
  localparam int DB = 1000;
`ifdef RESET_SEQUENCER_WDT_EN
  localparam int WDT = 100;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NL-1:0] locks;
  logic          btn_n, sw, clr;
  logic [NS-1:0] rst_o;
  logic          rdy, lost;
`ifdef RESET_SEQUENCER_WDT_EN
  logic          kick, fired;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: phase 0=held, 1=waiting for lock, 2=released; m_age = cycles spent in the phase.
  int            m_phase, m_age, m_dcnt, m_w;
  bit            m_lost, m_db, m_fired, m_bs1, m_bs2;
  logic [NL-1:0] m_ls1, m_ls2;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_LOCKS(NL), .NUM_STAGES(NS), .MIN_HOLD(MH),
    .LOCK_STABLE_CYCLES(LS), .STAGE_DELAY(SD), .DEBOUNCE_CYCLES(DB)
`ifdef RESET_SEQUENCER_WDT_EN
    , .WDT_CYCLES(WDT)
`endif
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .pll_locked_i(locks), .btn_n_i(btn_n),
    .sw_reset_i(sw), .lost_lock_clr_i(clr),
`ifdef RESET_SEQUENCER_WDT_EN
    .wdt_kick_i(kick), .wdt_fired_o(fired),
`endif
    .reset_o(rst_o), .ready_o(rdy), .lost_lock_o(lost)
  );

  task automatic model_reset();
    m_phase = 0; m_age = 0; m_dcnt = 0; m_w = 0;
    m_lost = 0; m_db = 0; m_fired = 0;
    m_bs1 = 1; m_bs2 = 1; m_ls1 = '0; m_ls2 = '0;
  endtask

  task automatic model_edge();
    bit locked, user, run, wfire, lset, abort, kk;
    locked = (&m_ls2);
    user   = m_db || sw;
    run    = (m_phase == 2) && (m_age >= SD * (NS - 1));
    wfire  = 0;
    kk     = 0;
`ifdef RESET_SEQUENCER_WDT_EN
    kk    = kick;
    wfire = run && !kick && (m_w == WDT - 1);
`endif
    lset  = 0;
    abort = 0;
    case (m_phase)
      0: begin
        if (user) m_age = 0;
        else if (m_age == MH) begin m_phase = 1; m_age = 0; end
        else m_age++;
      end
      1: begin
        if (user) begin m_phase = 0; m_age = 0; end
        else if (!locked) m_age = 0;
        else if (m_age == LS - 1) begin m_phase = 2; m_age = 0; end
        else m_age++;
      end
      default: begin
        abort = user || !locked || wfire;
        if (abort) begin m_phase = 0; m_age = 0; lset = !locked; end
        else if (m_age < SD * (NS - 1)) m_age++;
      end
    endcase
    if (run && !abort && !kk) m_w++;
    else m_w = 0;
    if (lset) m_lost = 1;
    else if (clr) m_lost = 0;
    if (wfire) m_fired = 1;
    else if (clr) m_fired = 0;
    if ((!m_bs2) != m_db) begin
      m_dcnt++;
      if (m_dcnt == DB) begin m_db = !m_db; m_dcnt = 0; end
    end else begin
      m_dcnt = 0;
    end
    m_ls2 = m_ls1; m_ls1 = locks;
    m_bs2 = m_bs1; m_bs1 = btn_n;
  endtask

  function automatic logic [31:0] model_vec();
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < NS; k++) v[k] = !((m_phase == 2) && (m_age >= SD * k));
    v[NS]   = (m_phase == 2) && (m_age >= SD * (NS - 1));
    v[NS+1] = m_lost;
`ifdef RESET_SEQUENCER_WDT_EN
    v[NS+2] = m_fired;
`endif
    return v;
  endfunction

  function automatic logic [31:0] dut_vec();
    logic [31:0] v;
    v = '0;
    v[NS-1:0] = rst_o;
    v[NS]     = rdy;
    v[NS+1]   = lost;
`ifdef RESET_SEQUENCER_WDT_EN
    v[NS+2]   = fired;
`endif
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) begin model_reset(); cyc = 0; end
    else begin model_edge(); cyc++; end
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int            n;
    logic [NL-1:0] lk;
    logic          bn;
    logic          swr;
    logic          cl;
    logic [NS-1:0] ersts;
    logic          erdy;
    logic          elost;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int lk_hold;
    int bt_hold;

    tbl[0]  = '{68, 2'b11, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0};
    tbl[1]  = '{1,  2'b11, 1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0};
    tbl[2]  = '{15, 2'b11, 1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0};
    tbl[3]  = '{1,  2'b11, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0};
    tbl[4]  = '{15, 2'b11, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0};
    tbl[5]  = '{1,  2'b11, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
    tbl[6]  = '{4,  2'b11, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
    tbl[7]  = '{2,  2'b10, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};
    tbl[8]  = '{1,  2'b10, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b1};
    tbl[9]  = '{20, 2'b10, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b1};
    tbl[10] = '{1,  2'b11, 1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 1'b0};
    tbl[11] = '{64, 2'b11, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0};
    tbl[12] = '{1,  2'b11, 1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0};
    tbl[13] = '{32, 2'b11, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0};

    rst_n = 1'b0; locks = '1; btn_n = 1'b1; sw = 1'b0; clr = 1'b0;
`ifdef RESET_SEQUENCER_WDT_EN
    kick = 1'b0;
`endif
    do_reset();
    check("reset_state", {29'd0, rst_o, rdy, lost}, {29'd0, 3'b111, 1'b0, 1'b0});

    // Release latency, lock loss in RUN, relock and sticky clear.
    for (int i = 0; i < 14; i++) begin
      locks = tbl[i].lk; btn_n = tbl[i].bn; sw = tbl[i].swr; clr = tbl[i].cl;
      repeat (tbl[i].n) step();
      check($sformatf("tbl%0d", i), {29'd0, rst_o, rdy, lost},
            {29'd0, tbl[i].ersts, tbl[i].erdy, tbl[i].elost});
    end
    clr = 1'b0;

    // Short lock glitch while waiting for lock delays release to cycle 114.
    do_reset();
    repeat (45) step();
    locks = 2'b01;
    repeat (3) step();
    locks = 2'b11;
    while (cyc < 113) step();
    check("glitch_before", {29'd0, rst_o}, {29'd0, 3'b111});
    step();
    check("glitch_release", {29'd0, rst_o, lost}, {29'd0, 3'b110, 1'b0});

    // Software request mid-release reasserts everything on the next edge.
    repeat (5) step();
    sw = 1'b1;
    step();
    sw = 1'b0;
    check("sw_abort", {29'd0, rst_o, rdy, lost}, {29'd0, 3'b111, 1'b0, 1'b0});
    while (cyc < 188) step();
    check("sw_restart_hold", {29'd0, rst_o}, {29'd0, 3'b111});
    step();
    check("sw_restart_rel", {29'd0, rst_o}, {29'd0, 3'b110});
    while (cyc < 221) step();
    check("sw_restart_run", {29'd0, rst_o, rdy}, {29'd0, 3'b000, 1'b1});

    // Lock drop coinciding with a clear request: set wins.
    repeat (4) step();
    locks = 2'b10;
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("set_beats_clr", {29'd0, rst_o, rdy, lost}, {29'd0, 3'b111, 1'b0, 1'b1});
    locks = 2'b11;
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_alone", {31'd0, lost}, 32'd0);

    // Button bounce is ignored; a held press resets; release follows debounce, hold and lock window.
    do_reset();
    while (cyc < 101) step();
    check("btn_pre_run", {31'd0, rdy}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      btn_n = 1'b0;
      repeat (200 + $urandom_range(0, 700)) step();
      btn_n = 1'b1;
      repeat (200) step();
    end
    check("bounce_ignored", {29'd0, rst_o, rdy}, {29'd0, 3'b000, 1'b1});
    btn_n = 1'b0;
    repeat (1002) step();
    check("press_not_yet", {31'd0, rdy}, 32'd1);
    step();
    check("press_reset", {29'd0, rst_o, rdy}, {29'd0, 3'b111, 1'b0});
    repeat (50) step();
    btn_n = 1'b1;
    repeat (1070) step();
    check("btn_release_hold", {29'd0, rst_o}, {29'd0, 3'b111});
    step();
    check("btn_release_rel", {29'd0, rst_o, lost}, {29'd0, 3'b110, 1'b0});

`ifdef RESET_SEQUENCER_WDT_EN
    // Regular kicks keep RUN alive; silence fires after WDT cycles.
    do_reset();
    while (cyc < 101) step();
    for (int i = 0; i < 300; i++) begin
      kick = (i % 50 == 49);
      step();
    end
    kick = 1'b0;
    check("wdt_kicked", {30'd0, rdy, fired}, {30'd0, 1'b1, 1'b0});
    repeat (99) step();
    check("wdt_not_yet", {31'd0, rdy}, 32'd1);
    step();
    check("wdt_fire", {29'd0, rst_o, rdy, fired}, {29'd0, 3'b111, 1'b0, 1'b1});
    check("wdt_no_lost", {31'd0, lost}, 32'd0);
`endif

    // Random traffic against the model.
    do_reset();
    lk_hold = 0;
    bt_hold = 0;
    for (int i = 0; i < 6000; i++) begin
      sw  = ($urandom_range(0, 119) == 0);
      clr = ($urandom_range(0, 49) == 0);
`ifdef RESET_SEQUENCER_WDT_EN
      kick = ($urandom_range(0, 29) != 0) ? 1'b0 : 1'b1;
`endif
      if (lk_hold > 0) begin
        lk_hold--;
        if (lk_hold == 0) locks = '1;
      end else if ($urandom_range(0, 199) == 0) begin
        locks[$urandom_range(0, NL - 1)] = 1'b0;
        lk_hold = $urandom_range(1, 6);
      end
      if (bt_hold > 0) begin
        bt_hold--;
        if (bt_hold == 0) btn_n = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        btn_n = 1'b0;
        bt_hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1000, 1100) : $urandom_range(1, 40);
      end
      rst_n = ($urandom_range(0, 1999) != 0);
      step();
      rst_n = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
